rx_ring_writer: RTL and testbench
=================================

Name: rx_ring_writer

Overview:
- Upstream producer for the 32 x 48-bit receive ring RAM (simple dual-port, byte-enabled).
- Accepts an 8-bit RX byte stream with valid/ready/last, packs 6 bytes per ring word, and drives the RAM write port with byte enables.
- Maintains the ring write pointer against a consumer-supplied read pointer and applies backpressure when the ring is full.
- Emits a per-frame completion pulse carrying the frame byte length.

Parameters:
- ADDR_WIDTH, 5, ring address width; depth = 2**ADDR_WIDTH = 32.
- BYTES_PER_WORD, 6, bytes per ring word; word width = 8*BYTES_PER_WORD = 48.
- LEN_WIDTH, 16, width of the frame byte-length counter.

Ports:
- clk  in  1  single clock for all logic; the ring write clock.
- rst_n  in  1  synchronous, active-low reset.
- in_data  in  8  RX byte.
- in_valid  in  1  in_data valid.
- in_last  in  1  last byte of frame, qualified by in_valid.
- in_ready  out  1  block accepts a byte this cycle.
- ram_wr_data  out  48  to RAM wr_data.
- ram_wr_addr  out  5  to RAM wr_addr.
- ram_wr_en  out  1  to RAM wr_en.
- ram_wr_byte_en  out  6  to RAM wr_byte_en.
- rd_ptr  in  ADDR_WIDTH+1  consumer's extended read pointer, same clock domain.
- wr_ptr  out  ADDR_WIDTH+1  extended write pointer: next free word plus wrap bit.
- used_words  out  ADDR_WIDTH+1  wr_ptr - rd_ptr, range 0..32.
- frame_done  out  1  one-cycle pulse on the final word write of a frame.
- frame_len  out  LEN_WIDTH  byte count of the completed frame; valid while frame_done=1.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low (rst_n sampled on the clk rising edge).
- Reset values:
  - All outputs 0: ram_wr_en, ram_wr_data, ram_wr_addr, ram_wr_byte_en, wr_ptr, used_words, frame_done, frame_len.
  - Internal lane index, assembly buffer, byte-enable accumulator and length counter all 0.
  - in_ready=1 after reset, since used_words=0.
- Handshake and capacity:
  - A byte is accepted when in_valid && in_ready.
  - in_ready = (used_words != 32), combinational from registered wr_ptr and the rd_ptr input.
  - in_valid is ignored when not accepted.
  - in_data and in_last must stay stable while in_valid=1 and in_ready=0.
- Packing:
  - Accepted byte goes to lane idx, bits [8*idx+7:8*idx]. Lane 0 holds the first byte (little-endian). The matching enable bit is set.
  - idx increments per accepted byte.
- Word completion: a word completes when an accepted byte lands in lane 5 or carries in_last. On the following cycle (1-cycle latency):
  - ram_wr_en=1.
  - ram_wr_data = assembled word; unwritten lanes are 0.
  - ram_wr_byte_en = accumulated enables (partial on a short last word, e.g. 6'b000111).
  - ram_wr_addr = wr_ptr[4:0].
  - wr_ptr increments in the same cycle. It wraps 31->0 on the address bits and toggles bit 5.
  - idx, buffer and enables clear so back-to-back bytes continue without a bubble.
- Length counting and frame completion:
  - The length counter increments per accepted byte and saturates at 2**LEN_WIDTH-1.
  - On the write cycle of an in_last word: frame_done=1 and frame_len = final count (including the last byte). The counter then resets to 0.
- used_words = wr_ptr - rd_ptr, modulo 64, registered-pointer based. It includes the word currently being written.
  - A byte completing a word is accepted at used_words=31, giving 32 after the write.
  - At 32, no bytes are accepted, including partial-lane bytes.
- Simultaneous rd_ptr advance and write: both take effect; used_words reflects both next cycle.
- Reset asserted mid-frame: the partial word is discarded with no write and no frame_done. Pointers return to 0; the consumer must reset its rd_ptr coincidentally.
- Frames are at least 1 byte; in_last on the first byte yields a single-lane word (byte_en 6'b000001, frame_len=1).

Optional Feature:
- Macro: RX_RING_WRITER_FRAME_CNT_EN.
- When defined:
  - Adds output frame_cnt[15:0], reset 0.
  - Increments on each frame_done and wraps 65535->0.
- When undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package rx_ring_pkg holds:
  - RX_RING_ADDR_W=5, RX_RING_BYTES=6, RX_RING_DATA_W=48, RX_RING_LEN_W=16.
  - A ring pointer typedef, ADDR_W+1 bits.
- One natural sub-module: rx_ring_byte_packer, covering lane index, assembly buffer, enables and completion strobe.
- The top level holds pointer, occupancy, length and frame logic.

Test Plan:
- 12-byte frame 0x01..0x0C, in_valid continuous, rd_ptr=0 -> two writes:
  - addr 0: data 0x060504030201, be 6'h3F.
  - addr 1: data 0x0C0B0A090807, be 6'h3F.
  - frame_done with frame_len=12 on the second write; wr_ptr=2.
- 8-byte frame -> second write has be 6'b000011 and upper lanes 0; frame_len=8.
- rd_ptr held at 0, stream 200 bytes:
  - in_ready drops after the 32nd word (192 bytes); used_words=32.
  - Advancing rd_ptr to 1 reasserts in_ready next cycle; the next write lands at addr 0 with wr_ptr=6'd33.
- Back-to-back frames of 1 and 6 bytes:
  - Writes at consecutive addresses with be 6'h01 and 6'h3F.
  - Two frame_done pulses with len 1 and 6; no lane leakage between frames.
- rst_n low after 4 bytes of a frame -> no write, all outputs 0. A subsequent 6-byte frame writes addr 0.
- With RX_RING_WRITER_FRAME_CNT_EN: 3 frames -> frame_cnt=3. Preload to 65535 via 65536 frames (or force) -> wraps to 0.

Source files
------------

// File: rtl/rx_ring_pkg.sv
// rx_ring_pkg
// Sizes shared by the receive-ring writer and its byte packer, plus the
// extended ring pointer type. The pointer is one bit wider than the ring
// address so that "full" and "empty" can be told apart.
package rx_ring_pkg;
   localparam int RX_RING_ADDR_W = 5;
   localparam int RX_RING_BYTES  = 6;
   localparam int RX_RING_DATA_W = 8 * RX_RING_BYTES;
   localparam int RX_RING_LEN_W  = 16;

   // Ring address bits plus the wrap bit.
   typedef logic [RX_RING_ADDR_W:0] rx_ring_ptr_t;
endpackage

// File: rtl/rx_ring_byte_packer.sv
// rx_ring_byte_packer
// Packs accepted bytes little-endian into a ring word and presents the
// finished word one cycle after its final byte is accepted.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   accept_i       a byte is accepted this cycle
//   byte_i         the byte being accepted
//   last_i         the accepted byte ends its frame
//   complete_o     combinational: this accept finishes a word
//   word_valid_o   registered: finished word is on word_data_o/word_be_o
//   word_data_o    finished word, unwritten lanes zero
//   word_be_o      lane enables of the finished word
module rx_ring_byte_packer
   import rx_ring_pkg::*;
#(
   parameter int BYTES_PER_WORD = RX_RING_BYTES
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          accept_i,
   input  logic [7:0]                    byte_i,
   input  logic                          last_i,
   output logic                          complete_o,
   output logic                          word_valid_o,
   output logic [8*BYTES_PER_WORD-1:0]   word_data_o,
   output logic [BYTES_PER_WORD-1:0]     word_be_o
);
   localparam int IDX_W  = $clog2(BYTES_PER_WORD);
   localparam int WORD_W = 8 * BYTES_PER_WORD;

   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [WORD_W-1:0]         buf_q, buf_d;
   logic [BYTES_PER_WORD-1:0] be_q, be_d;
   logic                      word_valid_q, word_valid_d;
   logic [WORD_W-1:0]         word_data_q, word_data_d;
   logic [BYTES_PER_WORD-1:0] word_be_q, word_be_d;

   // Assembly buffer with this cycle's byte merged into its lane.
   logic [WORD_W-1:0]         merged_data;
   logic [BYTES_PER_WORD-1:0] merged_be;

   generate
      for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
         logic hit;
         assign hit                     = accept_i && (idx_q == IDX_W'(gi));
         assign merged_data[8*gi +: 8]  = hit ? byte_i : buf_q[8*gi +: 8];
         assign merged_be[gi]           = hit | be_q[gi];
      end
   endgenerate

   assign complete_o = accept_i && (last_i || (idx_q == IDX_W'(BYTES_PER_WORD - 1)));

   always_comb begin
      idx_d        = idx_q;
      buf_d        = buf_q;
      be_d         = be_q;
      word_valid_d = complete_o;
      word_data_d  = word_data_q;
      word_be_d    = word_be_q;
      if (complete_o) begin
         // Hand the word off and clear at once so the next byte can land
         // in lane 0 on the very next cycle.
         word_data_d = merged_data;
         word_be_d   = merged_be;
         idx_d       = '0;
         buf_d       = '0;
         be_d        = '0;
      end else if (accept_i) begin
         buf_d = merged_data;
         be_d  = merged_be;
         idx_d = idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q        <= '0;
         buf_q        <= '0;
         be_q         <= '0;
         word_valid_q <= 1'b0;
         word_data_q  <= '0;
         word_be_q    <= '0;
      end else begin
         idx_q        <= idx_d;
         buf_q        <= buf_d;
         be_q         <= be_d;
         word_valid_q <= word_valid_d;
         word_data_q  <= word_data_d;
         word_be_q    <= word_be_d;
      end
   end

   assign word_valid_o = word_valid_q;
   assign word_data_o  = word_data_q;
   assign word_be_o    = word_be_q;
endmodule

// File: rtl/rx_ring_writer.sv
// rx_ring_writer
// Producer side of the 32 x 48-bit receive ring: packs an RX byte stream
// into ring words, writes them through the RAM write port, keeps the write
// pointer against the consumer's read pointer (backpressure when full) and
// pulses frame_done with the frame length on the last word of each frame.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   in_data/in_valid/in_last/in_ready   byte stream handshake
//   ram_wr_data/addr/en/byte_en     ring RAM write port
//   rd_ptr                          consumer extended read pointer
//   wr_ptr                          extended write pointer
//   used_words                      wr_ptr - rd_ptr (0..32)
//   frame_done/frame_len            frame completion pulse and length
//   frame_cnt                       completed-frame counter, present only
//                                   with RX_RING_WRITER_FRAME_CNT_EN defined
module rx_ring_writer
   import rx_ring_pkg::*;
#(
   parameter int ADDR_WIDTH     = RX_RING_ADDR_W,
   parameter int BYTES_PER_WORD = RX_RING_BYTES,
   parameter int LEN_WIDTH      = RX_RING_LEN_W
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [7:0]                    in_data,
   input  logic                          in_valid,
   input  logic                          in_last,
   output logic                          in_ready,
   output logic [8*BYTES_PER_WORD-1:0]   ram_wr_data,
   output logic [ADDR_WIDTH-1:0]         ram_wr_addr,
   output logic                          ram_wr_en,
   output logic [BYTES_PER_WORD-1:0]     ram_wr_byte_en,
   input  logic [ADDR_WIDTH:0]           rd_ptr,
   output logic [ADDR_WIDTH:0]           wr_ptr,
   output logic [ADDR_WIDTH:0]           used_words,
   output logic                          frame_done,
   output logic [LEN_WIDTH-1:0]          frame_len
`ifdef RX_RING_WRITER_FRAME_CNT_EN
   ,
   output logic [15:0]                   frame_cnt
`endif
);
   localparam logic [ADDR_WIDTH:0] FULL_WORDS = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);

   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  len_sat;
   logic                  done_q, done_d;
   logic [LEN_WIDTH-1:0]  frame_len_q, frame_len_d;
   logic                  accept;
   logic                  complete;

   // Occupancy counts the word being written this cycle, because the
   // pointer advances on the same edge that raises ram_wr_en.
   assign used_words = wr_ptr_q - rd_ptr;
   assign in_ready   = (used_words != FULL_WORDS);
   assign accept     = in_valid && in_ready;

   rx_ring_byte_packer #(
      .BYTES_PER_WORD (BYTES_PER_WORD)
   ) u_packer (
      .clk          (clk),
      .rst_n        (rst_n),
      .accept_i     (accept),
      .byte_i       (in_data),
      .last_i       (in_last),
      .complete_o   (complete),
      .word_valid_o (ram_wr_en),
      .word_data_o  (ram_wr_data),
      .word_be_o    (ram_wr_byte_en)
   );

   // Length including the byte accepted this cycle; sticks at all-ones.
   assign len_sat = (len_q == '1) ? len_q : len_q + 1'b1;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      addr_d      = addr_q;
      len_d       = len_q;
      done_d      = complete && in_last;
      frame_len_d = done_d ? len_sat : '0;
      if (accept) begin
         len_d = done_d ? '0 : len_sat;
      end
      if (complete) begin
         addr_d   = wr_ptr_q[ADDR_WIDTH-1:0];
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         done_q      <= 1'b0;
         frame_len_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         done_q      <= done_d;
         frame_len_q <= frame_len_d;
      end
   end

   assign wr_ptr      = wr_ptr_q;
   assign ram_wr_addr = addr_q;
   assign frame_done  = done_q;
   assign frame_len   = frame_len_q;

`ifdef RX_RING_WRITER_FRAME_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (done_d) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign frame_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_rx_ring_writer.sv
module tb_rx_ring_writer;
   logic        clk;
   logic        rst_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [47:0] ram_wr_data;
   logic [4:0]  ram_wr_addr;
   logic        ram_wr_en;
   logic [5:0]  ram_wr_byte_en;
   logic [5:0]  rd_ptr;
   logic [5:0]  wr_ptr;
   logic [5:0]  used_words;
   logic        frame_done;
   logic [15:0] frame_len;
`ifdef RX_RING_WRITER_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   rx_ring_writer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_last        (in_last),
      .in_ready       (in_ready),
      .ram_wr_data    (ram_wr_data),
      .ram_wr_addr    (ram_wr_addr),
      .ram_wr_en      (ram_wr_en),
      .ram_wr_byte_en (ram_wr_byte_en),
      .rd_ptr         (rd_ptr),
      .wr_ptr         (wr_ptr),
      .used_words     (used_words),
      .frame_done     (frame_done),
      .frame_len      (frame_len)
`ifdef RX_RING_WRITER_FRAME_CNT_EN
      ,
      .frame_cnt      (frame_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   // Bytes accepted so far in the open word, words written (mod 64),
   // running frame length, and what the write port must show after this edge.
   int          m_words  = 0;
   int          m_nb     = 0;
   int          m_len    = 0;
   int          m_frames = 0;
   logic [7:0]  m_bytes[6];
   bit          e_valid  = 0;
   logic [47:0] e_data   = '0;
   logic [5:0]  e_be     = '0;
   logic [4:0]  e_addr   = '0;
   bit          e_done   = 0;
   int          e_len    = 0;

   always @(posedge clk) begin
      int used;
      e_valid = 0;
      e_done  = 0;
      if (!rst_n) begin
         m_words = 0; m_nb = 0; m_len = 0; m_frames = 0;
      end else begin
         used = (m_words - int'(rd_ptr)) & 63;
         if (in_valid && used != 32) begin
            m_bytes[m_nb] = in_data;
            m_nb++;
            if (m_len < 65535) m_len++;
            if (m_nb == 6 || in_last) begin
               e_data = '0;
               for (int k = 0; k < m_nb; k++) e_data = e_data | (48'(m_bytes[k]) << (8 * k));
               e_be    = 6'((1 << m_nb) - 1);
               e_addr  = 5'(m_words % 32);
               e_valid = 1;
               m_words = (m_words + 1) % 64;
               if (in_last) begin
                  e_done = 1;
                  e_len  = m_len;
                  m_len  = 0;
                  m_frames++;
               end
               m_nb = 0;
            end
         end
      end
   end

   typedef struct {
      logic [4:0]  addr;
      logic [47:0] data;
      logic [5:0]  be;
      logic        done;
      logic [15:0] len;
   } wr_t;
   wr_t log_q[$];

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      int used;
      wr_t w;
      used = (m_words - int'(rd_ptr)) & 63;
      chk("wr_en",      {63'd0, ram_wr_en}, {63'd0, e_valid});
      if (e_valid) begin
         chk("wr_data", {16'd0, ram_wr_data}, {16'd0, e_data});
         chk("wr_be",   {58'd0, ram_wr_byte_en}, {58'd0, e_be});
         chk("wr_addr", {59'd0, ram_wr_addr}, {59'd0, e_addr});
      end
      chk("frame_done", {63'd0, frame_done}, {63'd0, e_done});
      if (e_done) chk("frame_len", {48'd0, frame_len}, 64'(e_len));
      chk("wr_ptr",     {58'd0, wr_ptr}, 64'(m_words));
      chk("used_words", {58'd0, used_words}, 64'(used));
      chk("in_ready",   {63'd0, in_ready}, {63'd0, used != 32});
`ifdef RX_RING_WRITER_FRAME_CNT_EN
      chk("frame_cnt",  {48'd0, frame_cnt}, 64'(m_frames & 16'hFFFF));
`endif
      if (ram_wr_en) begin
         w.addr = ram_wr_addr; w.data = ram_wr_data; w.be = ram_wr_byte_en;
         w.done = frame_done;  w.len  = frame_len;
         log_q.push_back(w);
      end
   end

   // ---------------- driver ----------------
   // Driver actions happen 2 time units after the falling edge.
   task automatic idle(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (n) begin @(negedge clk); #2; end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l);
      bit rdy;
      bit acc;
      in_data  = d;
      in_last  = l;
      in_valid = 1'b1;
      acc      = 0;
      for (int t = 0; t < 50; t++) begin
         #1;
         rdy = in_ready;
         @(posedge clk);
         @(negedge clk); #2;
         if (rdy) begin acc = 1; break; end
      end
      if (!acc) chk("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame(input int n, input logic [7:0] first);
      for (int i = 0; i < n; i++) send_byte(first + 8'(i), i == n - 1);
      idle(2);
   endtask

   task automatic chk_log(input string name, input int i, input logic [4:0] addr,
                          input logic [47:0] data, input logic [5:0] be,
                          input logic done, input logic [15:0] len);
      if (i >= log_q.size()) begin
         chk({name, "_present"}, 64'(log_q.size()), 64'(i + 1));
      end else begin
         chk({name, "_addr"}, {59'd0, log_q[i].addr}, {59'd0, addr});
         chk({name, "_data"}, {16'd0, log_q[i].data}, {16'd0, data});
         chk({name, "_be"},   {58'd0, log_q[i].be},   {58'd0, be});
         chk({name, "_done"}, {63'd0, log_q[i].done}, {63'd0, done});
         if (done) chk({name, "_len"}, {48'd0, log_q[i].len}, {48'd0, len});
      end
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_wr_en"}, {63'd0, ram_wr_en}, 64'd0);
      chk({name, "_data"},  {16'd0, ram_wr_data}, 64'd0);
      chk({name, "_addr"},  {59'd0, ram_wr_addr}, 64'd0);
      chk({name, "_be"},    {58'd0, ram_wr_byte_en}, 64'd0);
      chk({name, "_wrptr"}, {58'd0, wr_ptr}, 64'd0);
      chk({name, "_used"},  {58'd0, used_words}, 64'd0);
      chk({name, "_done"},  {63'd0, frame_done}, 64'd0);
      chk({name, "_len"},   {48'd0, frame_len}, 64'd0);
      chk({name, "_ready"}, {63'd0, in_ready}, 64'd1);
   endtask

   initial begin
      rst_n    = 1'b0;
      rd_ptr   = '0;
      in_data  = '0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      idle(3);
      chk_all_zero("reset");
      rst_n = 1'b1;
      idle(1);

      // 12-byte frame: two full words
      log_q.delete();
      send_frame(12, 8'h01);
      chk("t12_nwr", 64'(log_q.size()), 64'd2);
      chk_log("t12_w0", 0, 5'd0, 48'h060504030201, 6'h3F, 1'b0, 16'd0);
      chk_log("t12_w1", 1, 5'd1, 48'h0C0B0A090807, 6'h3F, 1'b1, 16'd12);
      chk("t12_wrptr", {58'd0, wr_ptr}, 64'd2);
      $display("txn frame12 writes=%0d wr_ptr=%0d", log_q.size(), wr_ptr);

      // 8-byte frame: partial second word
      log_q.delete();
      send_frame(8, 8'h11);
      chk_log("t8_w0", 0, 5'd2, 48'h161514131211, 6'h3F, 1'b0, 16'd0);
      chk_log("t8_w1", 1, 5'd3, 48'h000000001817, 6'h03, 1'b1, 16'd8);
      $display("txn frame8 writes=%0d wr_ptr=%0d", log_q.size(), wr_ptr);

      // back-to-back 1-byte and 6-byte frames, no idle between them
      log_q.delete();
      send_byte(8'hA1, 1'b1);
      send_frame(6, 8'hB1);
      chk_log("t1_w0", 0, 5'd4, 48'h0000000000A1, 6'h01, 1'b1, 16'd1);
      chk_log("t6_w0", 1, 5'd5, 48'hB6B5B4B3B2B1, 6'h3F, 1'b1, 16'd6);
`ifdef RX_RING_WRITER_FRAME_CNT_EN
      chk("fcnt_lit", {48'd0, frame_cnt}, 64'd4);
`endif
      $display("txn frames1+6 writes=%0d wr_ptr=%0d", log_q.size(), wr_ptr);

      // reset mid-frame discards the partial word
      log_q.delete();
      for (int i = 0; i < 4; i++) send_byte(8'h51 + 8'(i), 1'b0);
      rst_n = 1'b0;
      idle(2);
      chk("rst_mid_nwr", 64'(log_q.size()), 64'd0);
      chk_all_zero("rst_mid");
      rst_n = 1'b1;
      idle(1);
      send_frame(6, 8'hC1);
      chk_log("post_rst", 0, 5'd0, 48'hC6C5C4C3C2C1, 6'h3F, 1'b1, 16'd6);
      chk("post_rst_wrptr", {58'd0, wr_ptr}, 64'd1);
      $display("txn reset_midframe writes=%0d wr_ptr=%0d", log_q.size(), wr_ptr);

      // fill the ring: 200-byte frame with rd_ptr held at 0
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
      log_q.delete();
      for (int i = 1; i <= 192; i++) send_byte(8'(i), 1'b0);
      in_data  = 8'd193;
      in_last  = 1'b0;
      in_valid = 1'b1;
      for (int t = 0; t < 3; t++) begin
         #1;
         chk("full_ready", {63'd0, in_ready}, 64'd0);
         chk("full_used", {58'd0, used_words}, 64'd32);
         @(negedge clk); #2;
      end
      rd_ptr = 6'd1;
      #1;
      chk("drain_ready", {63'd0, in_ready}, 64'd1);
      for (int i = 193; i <= 198; i++) send_byte(8'(i), 1'b0);
      chk_log("wrap_w", 32, 5'd0, 48'hC6C5C4C3C2C1, 6'h3F, 1'b0, 16'd0);
      chk("wrap_wrptr", {58'd0, wr_ptr}, 64'd33);
      rd_ptr = 6'd33;
      send_byte(8'd199, 1'b0);
      send_byte(8'd200, 1'b1);
      idle(2);
      chk_log("fill_last", 33, 5'd1, 48'h00000000C8C7, 6'h03, 1'b1, 16'd200);
      $display("txn fill200 writes=%0d wr_ptr=%0d", log_q.size(), wr_ptr);

      idle(2);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
